// File: rtl/pipe_skid_reg.sv
// Reusable pipeline-stage register with valid/ready handshake and flush.
// SKID=1 adds a second entry so in_ready comes straight from a flop.
module pipe_skid_reg #(
  parameter int                DATA_W    = 32,
  parameter int                SKID      = 1,
  parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              rdy_q;
  logic              in_fire, out_fire;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign count     = state_q;
  // Without a skid entry, ready must look through to the downstream consumer.
  assign in_ready  = (SKID != 0) ? rdy_q : (!out_valid | out_ready);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = RESET_VAL;
      skid_d  = RESET_VAL;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire && (SKID != 0)) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
            main_d  = RESET_VAL;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = RESET_VAL;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = RESET_VAL;
          skid_d  = RESET_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= (state_d != FULL);
    end
  end

endmodule
